spi_loopback_pattern_checker: RTL

//  Traffic source and checker for the SPI 4-wire loopback. Sends a deterministic word stream
//  (incrementing or PRBS) into the SPI master's TX side. Checks the words the SPI slave

---
 rtl/spi_lb_pkg.sv | 43 ++++
 rtl/spi_lb_pattern_gen.sv | 48 ++++
 rtl/spi_loopback_pattern_checker.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_lb_pkg.sv
// spi_lb_pkg: shared state type and pattern math
// for the SPI loopback pattern checker.
package spi_lb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } lb_state_t;

   // Maximal-length feedback masks, bit n-1 set for tap n
   localparam logic [31:0] TAPS [2:32] = '{
      32'h0000_0003, 32'h0000_0006, 32'h0000_000C,
      32'h0000_0014, 32'h0000_0030, 32'h0000_0060,
      32'h0000_00B8, 32'h0000_0110, 32'h0000_0240,
      32'h0000_0500, 32'h0000_0829, 32'h0000_100D,
      32'h0000_2015, 32'h0000_6000, 32'h0000_D008,
      32'h0001_2000, 32'h0002_0400, 32'h0004_0023,
      32'h0009_0000, 32'h0014_0000, 32'h0030_0000,
      32'h0042_0000, 32'h00E1_0000, 32'h0120_0000,
      32'h0200_0023, 32'h0400_0013, 32'h0900_0000,
      32'h1400_0000, 32'h2000_0029, 32'h4800_0000,
      32'h8020_0003
   };

   function automatic logic [31:0] next_word(
      input logic [31:0] cur,
      input logic        pattern,
      input int          width
   );
      logic [31:0] mask;
      logic [31:0] nxt;
      mask = (32'd1 << width) - 32'd1;
      if (pattern) begin
         nxt = {cur[30:0], ^(cur & TAPS[width[5:0]])};
      end else begin
         nxt = cur + 32'd1;
      end
      return nxt & mask;
   endfunction

endpackage

// File: rtl/spi_lb_pattern_gen.sv
// spi_lb_pattern_gen: seedable word stream, one word
// per advance; used for both transmit and expected data.
module spi_lb_pattern_gen
   import spi_lb_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int PATTERN    = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] seed_i,
   input  logic                  adv_i,
   output logic [DATA_WIDTH-1:0] word_o
);

   logic [DATA_WIDTH-1:0] word_q;
   logic [DATA_WIDTH-1:0] word_d;
   logic [DATA_WIDTH-1:0] seed_fix;

   // Load the seed (all-ones instead of a locked LFSR) or step
   always_comb begin
      seed_fix = seed_i;
      if (PATTERN != 0 && seed_i == '0) begin
         seed_fix = '1;
      end
      word_d = word_q;
      if (load_i) begin
         word_d = seed_fix;
      end else if (adv_i) begin
         word_d = DATA_WIDTH'(next_word(32'(word_q),
                                        1'(PATTERN),
                                        DATA_WIDTH));
      end
   end

   // Current word register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign word_o = word_q;

endmodule

// File: rtl/spi_loopback_pattern_checker.sv
// spi_loopback_pattern_checker: feeds a pattern stream to
// the SPI master and checks what the SPI slave receives.
module spi_loopback_pattern_checker
   import spi_lb_pkg::*;
#(
   parameter int DATA_WIDTH      = 16,
   parameter int PATTERN         = 1,
   parameter int WORD_NUM_WIDTH  = 16,
   parameter int MAX_OUTSTANDING = 2,
   parameter int TIMEOUT_CLK_NUM = 1024
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   input  logic [WORD_NUM_WIDTH-1:0] word_num,
   input  logic [DATA_WIDTH-1:0]     seed,
   output logic [DATA_WIDTH-1:0]     mst_tx_data,
   output logic                      mst_tx_valid,
   input  logic                      mst_tx_ready,
   input  logic [DATA_WIDTH-1:0]     slv_rx_data,
   input  logic                      slv_rx_valid,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [WORD_NUM_WIDTH-1:0] err_cnt,
   output logic [WORD_NUM_WIDTH-1:0] rx_cnt,
   output logic                      timeout
);

   localparam int TW = $clog2(TIMEOUT_CLK_NUM + 1);
   localparam logic [WORD_NUM_WIDTH-1:0] MAX_OUT =
      WORD_NUM_WIDTH'(MAX_OUTSTANDING);
   localparam logic [WORD_NUM_WIDTH-1:0] W_ONE = 1;
   localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CLK_NUM);
   localparam logic [TW-1:0] T_ONE  = 1;

   lb_state_t                 state_q, state_d;
   logic [WORD_NUM_WIDTH-1:0] wnum_q, wnum_d;
   logic [WORD_NUM_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
   logic [WORD_NUM_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
   logic [WORD_NUM_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic [TW-1:0]             to_cnt_q, to_cnt_d;
   logic                      timeout_q, timeout_d;
   logic                      pass_q, pass_d;
   logic [WORD_NUM_WIDTH-1:0] outst;
   logic                      load;
   logic                      active;
   logic                      tx_valid;
   logic                      tx_fire;
   logic                      rx_fire;
   logic [DATA_WIDTH-1:0]     tx_word;
   logic [DATA_WIDTH-1:0]     exp_word;

   spi_lb_pattern_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .PATTERN    (PATTERN)
   ) u_tx_gen (
      .clk    (clk),
      .rstn   (rstn),
      .load_i (load),
      .seed_i (seed),
      .adv_i  (tx_fire),
      .word_o (tx_word)
   );

   spi_lb_pattern_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .PATTERN    (PATTERN)
   ) u_exp_gen (
      .clk    (clk),
      .rstn   (rstn),
      .load_i (load),
      .seed_i (seed),
      .adv_i  (rx_fire),
      .word_o (exp_word)
   );

   // Run control, flow control, checking and timeout
   always_comb begin
      state_d   = state_q;
      wnum_d    = wnum_q;
      tx_cnt_d  = tx_cnt_q;
      rx_cnt_d  = rx_cnt_q;
      err_cnt_d = err_cnt_q;
      to_cnt_d  = to_cnt_q;
      timeout_d = timeout_q;
      pass_d    = pass_q;
      load      = 1'b0;
      outst     = tx_cnt_q - rx_cnt_q;
      active    = (state_q == RUN) || (state_q == DRAIN);
      tx_valid  = (state_q == RUN) && (tx_cnt_q != wnum_q)
                  && (outst != MAX_OUT);
      tx_fire   = tx_valid && mst_tx_ready;
      rx_fire   = active && slv_rx_valid;

      if (tx_fire) begin
         tx_cnt_d = tx_cnt_q + W_ONE;
      end
      if (rx_fire) begin
         rx_cnt_d = rx_cnt_q + W_ONE;
         if (slv_rx_data != exp_word && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + W_ONE;
         end
      end
      if (tx_fire || rx_fire) begin
         to_cnt_d = '0;
      end else if (active && outst != '0) begin
         to_cnt_d = to_cnt_q + T_ONE;
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               wnum_d    = word_num;
               tx_cnt_d  = '0;
               rx_cnt_d  = '0;
               err_cnt_d = '0;
               to_cnt_d  = '0;
               timeout_d = 1'b0;
               pass_d    = 1'b0;
               if (word_num == '0) begin
                  state_d = DONE;
                  pass_d  = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (to_cnt_q == TO_LIM) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end else if (tx_cnt_q == wnum_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (to_cnt_q == TO_LIM) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end else if (rx_cnt_q == wnum_q) begin
               state_d = DONE;
               pass_d  = (err_cnt_q == '0);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         wnum_q    <= '0;
         tx_cnt_q  <= '0;
         rx_cnt_q  <= '0;
         err_cnt_q <= '0;
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wnum_q    <= wnum_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
         err_cnt_q <= err_cnt_d;
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
         pass_q    <= pass_d;
      end
   end

   assign mst_tx_data  = tx_word;
   assign mst_tx_valid = tx_valid;
   assign busy         = active;
   assign done         = (state_q == DONE);
   assign pass         = pass_q;
   assign err_cnt      = err_cnt_q;
   assign rx_cnt       = rx_cnt_q;
   assign timeout      = timeout_q;

endmodule
